// File: rtl/eq4_code_driver.sv
// eq4_code_driver: programs an eq4 lock code with push1, or sweeps all codes with push2 to find the stored one.
module eq4_code_driver #(
  parameter int W             = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int PULSE_CYCLES  = 4,
  parameter int RESP_CYCLES   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         prog,
  input  logic [W-1:0] code_in,
  output logic [W-1:0] no,
  output logic         push1,
  output logic         push2,
  input  logic         ledpin,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [W-1:0] found_code,
  output logic [W:0]   trials
);
  localparam int CW = 8;
  typedef enum logic [2:0] {IDLE, SETUP, PUSH, WAIT, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic [W-1:0]  code_q, cand_q, no_q, found_code_q;
  logic          push1_q, push2_q, busy_q, done_q, found_q;
  logic [W:0]    trials_q;
  logic [W-1:0]  cand_d;
  assign cand_d = cand_q + W'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      code_q       <= '0;
      cand_q       <= '0;
      no_q         <= '0;
      push1_q      <= 1'b0;
      push2_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      found_code_q <= '0;
      trials_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q  <= SETUP;
          cnt_q    <= '0;
          mode_q   <= prog;
          cand_q   <= '0;
          found_q  <= 1'b0;
          trials_q <= '0;
          busy_q   <= 1'b1;
          no_q     <= prog ? code_in : '0;
          if (prog) code_q <= code_in;
        end
        SETUP: if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          state_q <= PUSH;
          cnt_q   <= '0;
          push1_q <= mode_q;
          push2_q <= !mode_q;
        end else cnt_q <= cnt_q + CW'(1);
        PUSH: if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
          cnt_q   <= '0;
          push1_q <= 1'b0;
          push2_q <= 1'b0;
          if (mode_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= WAIT;
            trials_q <= trials_q + (W+1)'(1);
          end
        end else cnt_q <= cnt_q + CW'(1);
        WAIT: if (cnt_q == CW'(RESP_CYCLES - 1)) begin
          cnt_q <= '0;
          // ledpin only matters on this final response cycle
          if (ledpin || cand_q == '1) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            found_q      <= ledpin;
            found_code_q <= ledpin ? cand_q : found_code_q;
          end else begin
            state_q <= SETUP;
            cand_q  <= cand_d;
            no_q    <= cand_d;
          end
        end else cnt_q <= cnt_q + CW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
  assign no         = no_q;
  assign push1      = push1_q;
  assign push2      = push2_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign found_code = found_code_q;
  assign trials     = trials_q;
  a_no_overlap: assert property (@(posedge clk) !(push1_q && push2_q));
endmodule

// File: tb/tb_eq4_code_driver.sv
// tb_eq4_code_driver: drives eq4_code_driver against a behavioural eq4 lock and scores results.
module tb_eq4_code_driver;
  logic clk = 0, reset = 1, start = 0, prog = 0, ledpin, tie0 = 0;
  logic [3:0] code_in = 0, no, found_code;
  logic push1, push2, busy, done, found;
  logic [4:0] trials;
  logic [3:0] key_q = 0;
  logic led_q = 0;
  int pass = 0, total = 0, overlap = 0;

  typedef struct {
    logic prog; logic [3:0] code; logic tie0;
    logic found; logic [3:0] fcode; logic [4:0] trials; int lat; logic [3:0] no;
  } vec_t;
  vec_t tbl[9];
  vec_t sb[$];

  eq4_code_driver dut (.clk(clk), .reset(reset), .start(start), .prog(prog), .code_in(code_in),
    .no(no), .push1(push1), .push2(push2), .ledpin(ledpin), .busy(busy), .done(done),
    .found(found), .found_code(found_code), .trials(trials));

  always #5 clk = ~clk;

  // eq4 lock: key latched on push1, match evaluated on push2 and held
  always @(posedge clk) begin
    if (push1) key_q <= no;
    if (push2) led_q <= (no == key_q);
    if (push1 && push2) overlap <= overlap + 1;
  end
  assign ledpin = tie0 ? 1'b0 : led_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run(input vec_t v);
    int cyc, p_first, p_last;
    vec_t e;
    tie0 = v.tie0;
    @(negedge clk);
    start = 1; prog = v.prog; code_in = v.code;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 0; cyc = 1; p_first = 0; p_last = 0;
    chk("no_cycle1", no, v.prog ? v.code : 4'h0);
    chk("busy_cycle1", busy, 1);
    while (!done && cyc < 400) begin
      if (push1) begin
        if (p_first == 0) p_first = cyc;
        p_last = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    chk("latency", cyc, e.lat);
    chk("found", found, e.found);
    if (e.found) chk("found_code", found_code, e.fcode);
    chk("trials", trials, e.trials);
    chk("no_hold", no, e.no);
    chk("busy_at_done", busy, 0);
    if (e.prog) begin
      chk("push1_first", p_first, 3);
      chk("push1_last", p_last, 6);
    end
    @(posedge clk); #1;
    chk("done_width", done, 0);
    chk("no_after_done", no, e.no);
  endtask

  initial begin
    int cyc, dn;
    vec_t v;
    tbl[0] = '{1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 5'd0,  7,   4'hA};
    tbl[1] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 5'd11, 100, 4'hA};
    tbl[2] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 5'd16, 145, 4'hF};
    tbl[3] = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 5'd0,  7,   4'h0};
    tbl[4] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 5'd1,  10,  4'h0};
    tbl[5] = '{1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 5'd0,  7,   4'h5};
    tbl[6] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'h5, 5'd6,  55,  4'h5};
    tbl[7] = '{1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 5'd0,  7,   4'hF};
    tbl[8] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 5'd16, 145, 4'hF};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {no, push1, push2, busy, done, found, found_code, trials}, 0);
    chk("reset_trials", trials, 0);
    reset = 0;
    for (int i = 0; i < 9; i++) run(tbl[i]);
    tie0 = 0;
    @(negedge clk);
    start = 1; prog = 0;
    @(posedge clk); #1;
    start = 0; cyc = 1; dn = 0;
    while (cyc < 20) begin
      start = (cyc == 5 || cyc == 12);
      @(posedge clk); #1;
      cyc++;
      if (done) dn++;
    end
    start = 0;
    chk("trials_before_reset", trials, 2);
    chk("busy_before_reset", busy, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("push2_at_reset", push2, 0);
    chk("outputs_at_reset", {no, push1, push2, busy, done, found, found_code, trials}, 0);
    @(posedge clk); #1;
    if (done) dn++;
    reset = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("no_done_after_abort", dn, 0);
    chk("idle_after_abort", busy, 0);
    v = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hF, 5'd16, 145, 4'hF};
    run(v);
    chk("no_push_overlap", overlap, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
